sync_timebase: RTL and testbench



---
 rtl/sync_pkg.sv | 16 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/sync_timebase.sv | 172 +++++++++++++++++
 tb/tb_sync_timebase.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared types and constants for the frame timebase and its channel consumers.
package sync_pkg;

  // Timebase operating state, exported for debug.
  typedef enum logic [1:0] {
    FREE     = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } sync_state_t;

  // Clocks from a syncin pin edge to the cycle in which the reload lands:
  // two synchroniser flops plus the edge-detect register.
  localparam int unsigned SYNC_LAT = 3;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous pin followed by a rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronise the pin, then keep a delayed copy to find the rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/sync_timebase.sv
// Frame timebase: free-running in master mode, phase-locked to syncin in slave mode,
// with lock qualification, loss detection and holdover that never disturbs the counter.
module sync_timebase
  import sync_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 20480000,
  parameter int unsigned OUT_FREQ    = 40000,
  parameter int unsigned PERIOD      = CLK_FREQ / OUT_FREQ,
  parameter int unsigned HIGH_CYCLES = PERIOD / 2,
  parameter int unsigned TOL         = 4,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned PW          = $clog2(PERIOD)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mode_slave,
  input  logic           syncin,
  input  logic [PW-1:0]  phase_offset,
  output logic           syncout,
  output logic [PW-1:0]  phase,
  output logic           period_start,
  output logic           locked,
  output sync_state_t    state
);

  localparam int unsigned IvMax = PERIOD + TOL + 1;
  localparam int unsigned IW    = $clog2(IvMax + 2);
  localparam int unsigned CW    = $clog2(LOCK_COUNT + 1);

  localparam logic [PW-1:0] PhaseLast = PW'(PERIOD - 1);
  localparam logic [PW-1:0] HighCyc   = PW'(HIGH_CYCLES);
  localparam logic [PW:0]   PeriodW   = (PW + 1)'(PERIOD);
  localparam logic [PW:0]   SyncLatW  = (PW + 1)'(SYNC_LAT);
  localparam logic [IW-1:0] IvSat     = IW'(IvMax);
  localparam logic [IW-1:0] IvLo      = IW'(PERIOD - TOL);
  localparam logic [IW-1:0] IvHi      = IW'(PERIOD + TOL);
  localparam logic [CW-1:0] LockCnt   = CW'(LOCK_COUNT);

  logic          rise;
  logic [IW-1:0] interval_q, interval_d;
  logic [IW-1:0] elapsed;
  logic          good;
  logic          timeout;
  logic          reload;
  logic [PW:0]   reload_sum;
  logic [PW-1:0] reload_val;
  logic [PW-1:0] phase_q, phase_d;
  logic          syncout_q;
  logic          period_start_q;
  logic          locked_q;
  logic [CW-1:0] count_q;
  sync_state_t   state_q;

  sync_edge_detect u_syncin (
    .clk     (clk),
    .reset   (reset),
    .async_i (syncin),
    .rise_o  (rise)
  );

  // Edge qualification, reload target and next counter values.
  always_comb begin
    // interval_q is cleared by the edge, so the clocks since that edge include this one.
    elapsed = interval_q + IW'(1);
    good    = (elapsed >= IvLo) && (elapsed <= IvHi);
    timeout = (elapsed >= IvSat);
    reload  = mode_slave && (state_q != FREE) && rise;

    if (rise) begin
      interval_d = '0;
    end else if (interval_q >= IvSat) begin
      interval_d = interval_q;
    end else begin
      interval_d = elapsed;
    end

    // Pre-advance by the detection latency so phase==offset at the pin edge.
    reload_sum = SyncLatW + {1'b0, phase_offset};
    if (reload_sum >= PeriodW) begin
      reload_val = PW'(reload_sum - PeriodW);
    end else begin
      reload_val = reload_sum[PW-1:0];
    end

    if (reload) begin
      phase_d = reload_val;
    end else if (phase_q == PhaseLast) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end
  end

  // Period counter, edge interval timer and the registered frame outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      interval_q     <= '0;
      phase_q        <= '0;
      syncout_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      interval_q     <= interval_d;
      phase_q        <= phase_d;
      syncout_q      <= (phase_q < HighCyc);
      period_start_q <= (phase_q == '0);
    end
  end

  // Lock state machine; count_q holds the number of edges in the current run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= mode_slave ? ACQUIRE : FREE;
      count_q  <= '0;
      locked_q <= 1'b0;
    end else if (!mode_slave) begin
      state_q  <= FREE;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          state_q  <= ACQUIRE;
          count_q  <= '0;
          locked_q <= 1'b0;
        end
        ACQUIRE: begin
          if (rise) begin
            // The first edge of a run only starts timing.
            if ((count_q == '0) || !good) begin
              count_q <= CW'(1);
            end else if (count_q >= LockCnt) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        LOCKED: begin
          // An edge takes priority over a coincident timeout.
          if (rise) begin
            if (!good) begin
              state_q  <= ACQUIRE;
              count_q  <= CW'(1);
              locked_q <= 1'b0;
            end
          end else if (timeout) begin
            state_q  <= HOLDOVER;
            locked_q <= 1'b0;
          end
        end
        HOLDOVER: begin
          if (rise) begin
            state_q <= ACQUIRE;
            count_q <= CW'(1);
          end
        end
        default: begin
          state_q  <= ACQUIRE;
          count_q  <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign syncout      = syncout_q;
  assign phase        = phase_q;
  assign period_start = period_start_q;
  assign locked       = locked_q;
  assign state        = state_q;

endmodule

// File: tb/tb_sync_timebase.sv
// Directed bench for sync_timebase at default parameters (PERIOD 512, TOL 4, LOCK_COUNT 4).
module tb_sync_timebase;
  import sync_pkg::*;

  logic        clk;
  logic        reset;
  logic        mode_slave;
  logic        syncin;
  logic [8:0]  phase_offset;
  logic        syncout;
  logic [8:0]  phase;
  logic        period_start;
  logic        locked;
  sync_state_t state;

  int n_checks = 0;
  int n_errors = 0;
  int hi_len;
  int lo_len;

  sync_timebase dut (
    .clk          (clk),
    .reset        (reset),
    .mode_slave   (mode_slave),
    .syncin       (syncin),
    .phase_offset (phase_offset),
    .syncout      (syncout),
    .phase        (phase),
    .period_start (period_start),
    .locked       (locked),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One syncin period: rising pin edge now, high for p/2, low for the rest.
  task automatic send_edge(input int p);
    syncin = 1'b1;
    step(p / 2);
    syncin = 1'b0;
    step(p - p / 2);
  endtask

  // Length of the current run of syncout at level lvl, bounded.
  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (syncout === lvl && len < 600) begin
      len++;
      step(1);
    end
  endtask

  initial begin
    reset        = 1'b1;
    mode_slave   = 1'b0;
    syncin       = 1'b0;
    phase_offset = '0;

    // Master mode reset and free-running 256/256 frame.
    step(3);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_syncout", 32'(syncout), 0);
    chk("rst_pstart", 32'(period_start), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_state_free", 32'(state), 32'(FREE));
    reset = 1'b0;
    step(1);
    chk("m_phase1", 32'(phase), 1);
    chk("m_syncout_hi", 32'(syncout), 1);
    chk("m_pstart_first", 32'(period_start), 1);
    run_len(1'b1, hi_len);
    chk("m_high_len", 32'(hi_len), 256);
    chk("m_pstart_mid", 32'(period_start), 0);
    run_len(1'b0, lo_len);
    chk("m_low_len", 32'(lo_len), 256);
    chk("m_pstart_next", 32'(period_start), 1);
    chk("m_phase_wrap", 32'(phase), 1);
    chk("m_locked", 32'(locked), 0);
    chk("m_state", 32'(state), 32'(FREE));

    // Slave lock: locked rises on the 5th detected edge.
    reset      = 1'b1;
    mode_slave = 1'b1;
    step(2);
    chk("s_rst_state", 32'(state), 32'(ACQUIRE));
    chk("s_rst_locked", 32'(locked), 0);
    reset = 1'b0;
    step(10);
    repeat (4) send_edge(512);
    chk("s_pre5_locked", 32'(locked), 0);
    chk("s_pre5_state", 32'(state), 32'(ACQUIRE));
    syncin = 1'b1;
    step(2);
    chk("s_e5_not_yet", 32'(locked), 0);
    step(1);
    chk("s_e5_locked", 32'(locked), 1);
    chk("s_e5_state", 32'(state), 32'(LOCKED));
    chk("s_e5_phase", 32'(phase), 3);
    step(253);
    syncin = 1'b0;
    step(256);
    chk("s_pin_phase0", 32'(phase), 0);
    chk("s_pin_syncout_lo", 32'(syncout), 0);
    syncin = 1'b1;
    step(1);
    chk("s_pin1_syncout_hi", 32'(syncout), 1);
    chk("s_pin1_pstart", 32'(period_start), 1);
    step(2);
    chk("s_pin3_phase", 32'(phase), 3);

    // Offset change mid-frame only applies at the next edge.
    phase_offset = 9'd100;
    step(1);
    chk("o_no_jump", 32'(phase), 4);
    step(252);
    syncin = 1'b0;
    step(256);
    chk("o_pin_old", 32'(phase), 0);
    syncin = 1'b1;
    step(3);
    chk("o_reload", 32'(phase), 103);
    chk("o_locked", 32'(locked), 1);
    step(253);
    syncin = 1'b0;
    step(256);
    chk("o_pin_phase100", 32'(phase), 100);
    chk("o_pin_syncout", 32'(syncout), 1);
    syncin = 1'b1;
    step(256);
    syncin = 1'b0;
    chk("o_mid_syncout", 32'(syncout), 0);
    step(156);
    chk("o_412_phase", 32'(phase), 0);
    chk("o_412_syncout", 32'(syncout), 0);
    step(1);
    chk("o_413_syncout", 32'(syncout), 1);
    chk("o_413_state", 32'(state), 32'(LOCKED));

    // Loss: timeout exactly PERIOD+TOL+1 clocks after the last reload.
    phase_offset = '0;
    step(106);
    chk("l_519_locked", 32'(locked), 1);
    step(1);
    chk("l_520_locked", 32'(locked), 0);
    chk("l_520_state", 32'(state), 32'(HOLDOVER));
    run_len(1'b1, hi_len);
    run_len(1'b0, lo_len);
    chk("l_hold_low", 32'(lo_len), 256);
    run_len(1'b1, hi_len);
    chk("l_hold_high", 32'(hi_len), 256);
    chk("l_hold_state", 32'(state), 32'(HOLDOVER));
    syncin = 1'b1;
    step(3);
    chk("l_restart_state", 32'(state), 32'(ACQUIRE));
    chk("l_restart_locked", 32'(locked), 0);
    step(253);
    syncin = 1'b0;
    step(256);
    repeat (3) send_edge(512);
    syncin = 1'b1;
    step(2);
    chk("l_relock_not_yet", 32'(locked), 0);
    step(1);
    chk("l_relock", 32'(locked), 1);
    chk("l_relock_state", 32'(state), 32'(LOCKED));
    step(253);
    syncin = 1'b0;
    step(5);

    // Reset while locked, then mode toggles.
    reset = 1'b1;
    step(1);
    chk("r_phase", 32'(phase), 0);
    chk("r_syncout", 32'(syncout), 0);
    chk("r_pstart", 32'(period_start), 0);
    chk("r_locked", 32'(locked), 0);
    chk("r_state", 32'(state), 32'(ACQUIRE));
    reset = 1'b0;
    step(37);
    chk("t_phase37", 32'(phase), 37);
    mode_slave = 1'b0;
    step(1);
    chk("t_free_state", 32'(state), 32'(FREE));
    chk("t_phase38", 32'(phase), 38);
    step(1);
    chk("t_phase39", 32'(phase), 39);
    mode_slave = 1'b1;
    step(1);
    chk("t_acq_state", 32'(state), 32'(ACQUIRE));
    chk("t_phase40", 32'(phase), 40);

    // Tolerance: period 515 locks.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);
    repeat (4) send_edge(515);
    syncin = 1'b1;
    step(2);
    chk("p515_not_yet", 32'(locked), 0);
    step(1);
    chk("p515_locked", 32'(locked), 1);
    step(254);
    syncin = 1'b0;
    step(20);

    // Period 517 never locks; each edge restarts the run at one.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);
    repeat (5) send_edge(517);
    chk("p517_locked", 32'(locked), 0);
    chk("p517_state", 32'(state), 32'(ACQUIRE));
    send_edge(512);
    chk("p517_e6_locked", 32'(locked), 0);
    repeat (3) send_edge(512);
    chk("p517_run_not_yet", 32'(locked), 0);
    syncin = 1'b1;
    step(2);
    chk("p517_run_e10_pre", 32'(locked), 0);
    step(1);
    chk("p517_run_locked", 32'(locked), 1);

    // Late edge coinciding with the timeout: the edge wins.
    step(253);
    syncin = 1'b0;
    step(261);
    syncin = 1'b1;
    step(2);
    chk("sim_pre_state", 32'(state), 32'(LOCKED));
    step(1);
    chk("sim_state_acq", 32'(state), 32'(ACQUIRE));
    chk("sim_locked", 32'(locked), 0);
    step(10);
    syncin = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
